// File: rtl/fetch_unit.sv
// Instruction fetch front end: 1-cycle-latency ROM reader feeding a 2-entry buffer to decode.
// Optional define FETCH_PERF_COUNTER_EN adds the fetch_count port counting delivered instructions.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 8
`endif

module fetch_unit #(
   parameter logic [`ROM_ADDRESS_BITWIDTH-1:0] RESET_PC = '0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   output logic [`ROM_ADDRESS_BITWIDTH-1:0] rom_address,
   input  logic [31:0]                      rom_data,
   input  logic                             redirect_valid,
   input  logic [`ROM_ADDRESS_BITWIDTH-1:0] redirect_pc,
   output logic                             inst_valid,
   input  logic                             inst_ready,
   output logic [31:0]                      inst,
   output logic [`ROM_ADDRESS_BITWIDTH-1:0] inst_pc
`ifdef FETCH_PERF_COUNTER_EN
   ,
   output logic [31:0]                      fetch_count
`endif
);

   localparam int W = `ROM_ADDRESS_BITWIDTH;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t         state, state_next;
   logic [W-1:0] pc, pc_next;
   logic         inflight;
   logic [W-1:0] inflight_pc;
   logic [31:0]  tail_inst;
   logic [W-1:0] tail_pc;

   logic         pop, capture, issue;
   logic         head_from_rom, head_from_tail, tail_from_rom;
   logic [1:0]   occ_num, pending;

   assign rom_address = pc;
   assign inst_valid  = (state != EMPTY);
   assign pop         = inst_valid & inst_ready;
   // A redirect squashes the fetch whose data is arriving this cycle.
   assign capture     = inflight & ~redirect_valid;

   always_comb begin
      occ_num = 2'd0;
      case (state)
         ONE:     occ_num = 2'd1;
         TWO:     occ_num = 2'd2;
         default: occ_num = 2'd0;
      endcase
   end

   assign pending = occ_num + {1'b0, inflight};

   always_comb begin
      state_next     = state;
      pc_next        = pc;
      issue          = 1'b0;
      head_from_rom  = 1'b0;
      head_from_tail = 1'b0;
      tail_from_rom  = 1'b0;
      if (redirect_valid) begin
         state_next = EMPTY;
         pc_next    = {redirect_pc[W-1:2], 2'b00};
      end else begin
         issue = (pending <= 2'd1) || ((pending == 2'd2) && pop);
         if (issue) pc_next = pc + W'(4);
         case (state)
            EMPTY: begin
               if (capture) begin
                  head_from_rom = 1'b1;
                  state_next    = ONE;
               end
            end
            ONE: begin
               case ({pop, capture})
                  2'b10: state_next = EMPTY;
                  2'b01: begin
                     tail_from_rom = 1'b1;
                     state_next    = TWO;
                  end
                  2'b11: head_from_rom = 1'b1;
                  default: state_next = ONE;
               endcase
            end
            TWO: begin
               if (pop) begin
                  head_from_tail = 1'b1;
                  if (capture) tail_from_rom = 1'b1;
                  else         state_next    = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= EMPTY;
         pc          <= {RESET_PC[W-1:2], 2'b00};
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         inflight <= issue;
         if (issue) inflight_pc <= pc;
      end
   end

   // Buffer storage: head drives decode directly, tail is the second slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst      <= '0;
         inst_pc   <= '0;
         tail_inst <= '0;
         tail_pc   <= '0;
      end else begin
         if (head_from_rom) begin
            inst    <= rom_data;
            inst_pc <= inflight_pc;
         end else if (head_from_tail) begin
            inst    <= tail_inst;
            inst_pc <= tail_pc;
         end
         if (tail_from_rom) begin
            tail_inst <= rom_data;
            tail_pc   <= inflight_pc;
         end
      end
   end

`ifdef FETCH_PERF_COUNTER_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  fetch_count <= '0;
      else if (pop)  fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, alignment, wrap and async reset.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 8
`endif

module tb_fetch_unit;

   localparam int W = `ROM_ADDRESS_BITWIDTH;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] rom_address;
   logic [31:0]  rom_data;
   logic         redirect_valid;
   logic [W-1:0] redirect_pc;
   logic         inst_valid;
   logic         inst_ready;
   logic [31:0]  inst;
   logic [W-1:0] inst_pc;
`ifdef FETCH_PERF_COUNTER_EN
   logic [31:0]  fetch_count;
`endif

   int total = 0;
   int bad   = 0;

   fetch_unit #(.RESET_PC('0)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
`ifdef FETCH_PERF_COUNTER_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   // ROM: word i holds value i, one-cycle read latency.
   always_ff @(posedge clk) rom_data <= 32'(rom_address[W-1:2]);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_inst(input string tag, input logic [31:0] word);
      chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
      chk({tag, "_inst"}, inst, word);
      chk({tag, "_pc"}, 32'(inst_pc), 32'(word << 2) & ((32'd1 << W) - 32'd1));
   endtask

   initial begin
      reset_n        = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      step();
      step();
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", 32'(inst_pc), 32'd0);
      chk("rst_addr", 32'(rom_address), 32'd0);

      // Release reset with decode always ready: one instruction per cycle.
      reset_n    = 1'b1;
      inst_ready = 1'b1;
      step();
      chk("first_issue_addr", 32'(rom_address), 32'd4);
      chk("first_issue_valid", 32'(inst_valid), 32'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         chk_inst($sformatf("stream%0d", k), 32'(k));
      end

      // Stall five cycles with word 7 at the head.
      inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_inst($sformatf("stall%0d", k), 32'd7);
         chk($sformatf("stall%0d_addr", k), 32'(rom_address), 32'd36);
      end
      inst_ready = 1'b1;
      for (int k = 8; k < 12; k++) begin
         step();
         chk_inst($sformatf("resume%0d", k), 32'(k));
      end

      // Fill buffer to TWO, then redirect to 0x40.
      inst_ready = 1'b0;
      step();
      chk_inst("fill_head", 32'd11);
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      step();
      chk("redir_flush_valid", 32'(inst_valid), 32'd0);
      chk("redir_addr", 32'(rom_address), 32'h40);
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      step();
      chk("redir_gap_valid", 32'(inst_valid), 32'd0);
      step();
      chk_inst("redir_first", 32'h10);
      step();
      chk_inst("redir_second", 32'h11);

      // Back-to-back redirects, latest unaligned target wins.
      redirect_valid = 1'b1;
      redirect_pc    = 8'h20;
      step();
      chk("b2b_first_addr", 32'(rom_address), 32'h20);
      chk("b2b_first_valid", 32'(inst_valid), 32'd0);
      redirect_pc = 8'h43;
      step();
      chk("b2b_align_addr", 32'(rom_address), 32'h40);
      redirect_valid = 1'b0;
      step();
      chk("b2b_gap_valid", 32'(inst_valid), 32'd0);
      step();
      chk_inst("b2b_first", 32'h10);
      step();
      chk_inst("b2b_second", 32'h11);

      // Wrap from the last ROM word back to 0.
      redirect_valid = 1'b1;
      redirect_pc    = 8'hF8;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      chk_inst("wrap62", 32'd62);
      step();
      chk_inst("wrap63", 32'd63);
      step();
      chk_inst("wrap0", 32'd0);
      step();
      chk_inst("wrap1", 32'd1);

      // Asynchronous reset mid-stream.
      reset_n = 1'b0;
      #1;
      chk("async_valid", 32'(inst_valid), 32'd0);
      chk("async_addr", 32'(rom_address), 32'd0);
      chk("async_inst", inst, 32'd0);
`ifdef FETCH_PERF_COUNTER_EN
      chk("async_count", fetch_count, 32'd0);
`endif
      step();
      chk("held_valid", 32'(inst_valid), 32'd0);
      reset_n = 1'b1;
      step();
      chk("restart_valid", 32'(inst_valid), 32'd0);
      chk("restart_addr", 32'(rom_address), 32'd4);
      step();
      chk_inst("restart0", 32'd0);
      step();
      chk_inst("restart1", 32'd1);
      step();
      chk_inst("restart2", 32'd2);
`ifdef FETCH_PERF_COUNTER_EN
      chk("count_pops", fetch_count, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
